// File: rtl/eth_rx_fcs_check.sv
// eth_rx_fcs_check -- receive-side Ethernet FCS checker.
//
// This block sits between the byte-wide MAC receive path and the frame buffer.
// It runs CRC-32 over every byte of a frame, including the 4 FCS bytes.
// A good frame leaves the register at the residue 32'hDEBB20E3.
// A 4-byte delay line strips the FCS, so it is never forwarded.
// At end of frame the block reports good/bad status and the frame length.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   rx_data[7:0]    received byte (LSB first on the wire)
//   rx_valid        rx_data valid this cycle
//   rx_sof/rx_eof   first / last (last FCS) byte, qualified by rx_valid
//   out_data[7:0]   payload byte with FCS removed
//   out_valid       out_data valid
//   out_sof/out_eof first / last payload byte
//   frame_done      one-cycle status strobe
//   frame_ok/err    status, valid with frame_done
//   frame_len[15:0] bytes received incl. FCS, saturating, valid with frame_done
//
// Optional: define ETH_RX_FCS_STATS_EN to add the stat_good, stat_bad and
// stat_runt counters. They are 32 bits wide and wrap.

module eth_rx_fcs_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_sof,
  input  logic        rx_eof,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [15:0] frame_len
`ifdef ETH_RX_FCS_STATS_EN
  ,
  output logic [31:0] stat_good,
  output logic [31:0] stat_bad,
  output logic [31:0] stat_runt
`endif
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [15:0] MIN16       = 16'(MIN_LEN);
  localparam logic [15:0] MAX16       = 16'(MAX_LEN);

  // Reflected CRC-32, eight bit steps per byte, LSB first.
  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, FILL, PASS} state_t;

  state_t          state;
  logic [31:0]     crc;
  logic [3:0][7:0] dly;        // dly[3] is the oldest held byte once 4 are held
  logic [2:0]      held;
  logic [15:0]     len;
  logic            first_out;

  logic [31:0] crc_sof, crc_nxt;
  logic [15:0] len_inc;
  logic        good;

  assign crc_sof = crc8(CRC_INIT, rx_data);
  assign crc_nxt = crc8(crc, rx_data);
  assign len_inc = (len == 16'hFFFF) ? len : len + 16'd1;
  // An eof seen in PASS means at least 5 bytes arrived. Shorter frames are
  // always bad, even if their bytes happen to hit the residue.
  assign good    = (state == PASS) && (crc_nxt == CRC_RESIDUE) &&
                   (len_inc >= MIN16) && (len_inc <= MAX16);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      crc        <= CRC_INIT;
      dly        <= '0;
      held       <= '0;
      len        <= '0;
      first_out  <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      frame_len  <= '0;
    end else begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      frame_len  <= '0;
      if (rx_valid) begin
        if (rx_sof) begin
          // A fresh frame starts on this byte. Any held bytes from an open
          // frame are dropped by resetting the held count.
          crc       <= crc_sof;
          dly       <= {dly[2:0], rx_data};
          held      <= 3'd1;
          len       <= 16'd1;
          first_out <= 1'b1;
          if (rx_eof) begin
            // Single-byte frame. If a frame was already open, its abort
            // report is superseded by this frame's status.
            state      <= IDLE;
            frame_done <= 1'b1;
            frame_err  <= 1'b1;
            frame_len  <= 16'd1;
          end else begin
            state <= FILL;
            if (state != IDLE) begin
              frame_done <= 1'b1;
              frame_err  <= 1'b1;
              frame_len  <= len;
            end
          end
        end else if (state != IDLE) begin
          crc <= crc_nxt;
          len <= len_inc;
          dly <= {dly[2:0], rx_data};
          if (state == PASS) begin
            out_valid <= 1'b1;
            out_data  <= dly[3];
            out_sof   <= first_out;
            out_eof   <= rx_eof;
            first_out <= 1'b0;
          end else begin
            held <= held + 3'd1;
            if (held == 3'd3) state <= PASS;
          end
          if (rx_eof) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            frame_ok   <= good;
            frame_err  <= !good;
            frame_len  <= len_inc;
          end
        end
      end
    end
  end

`ifdef ETH_RX_FCS_STATS_EN
  // The counters follow the registered status, so they settle one cycle after
  // frame_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_good <= '0;
      stat_bad  <= '0;
      stat_runt <= '0;
    end else if (frame_done) begin
      stat_good <= stat_good + {31'd0, frame_ok};
      stat_bad  <= stat_bad + {31'd0, frame_err};
      stat_runt <= stat_runt + {31'd0, (frame_len < MIN16)};
    end
  end
`endif

endmodule
